// File: rtl/vec_pkg.sv
// Shared definitions for the vector load/store units: FSM state encoding,
// write-strobe patterns, opcode/mop constants and small helpers.
package vec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } lsu_state_e;

   localparam logic [3:0] WSTRB_WORD  = 4'b1111;
   localparam logic [3:0] WSTRB_NONE  = 4'b0000;

   localparam logic [6:0] OPC_VLOAD   = 7'b0000111;
   localparam logic [6:0] OPC_VSTORE  = 7'b0100111;

   localparam logic [2:0] MOP_STRIDED = 3'b010;

   // True when the two low byte-address bits select a 32-bit word boundary.
   function automatic logic isWordAligned(input logic [1:0] lowBits);
      return (lowBits == 2'b00);
   endfunction

endpackage

// File: rtl/vec_lsu_addr_gen.sv
// Element counter plus byte-address accumulator for vector memory units.
// i_load captures base/stride/vl and restarts at element 0; i_step moves to
// the next element. o_last flags the final element of the command.
module vec_lsu_addr_gen #(
   parameter int VL_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_load,
   input  logic [31:0]     i_base,
   input  logic [31:0]     i_stride,
   input  logic [VL_W-1:0] i_vl,
   input  logic            i_step,
   output logic [31:0]     o_addr,
   output logic [VL_W-1:0] o_idx,
   output logic            o_last
);

   logic [31:0]     r_addr;
   logic [31:0]     r_stride;
   logic [VL_W-1:0] r_idx;
   logic [VL_W-1:0] r_vl;

   // Load restarts the walk; each step advances address (mod 2^32) and index.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr   <= '0;
         r_stride <= '0;
         r_idx    <= '0;
         r_vl     <= '0;
      end else if (i_load) begin
         r_addr   <= i_base;
         r_stride <= i_stride;
         r_idx    <= '0;
         r_vl     <= i_vl;
      end else if (i_step) begin
         r_addr   <= r_addr + r_stride;
         r_idx    <= r_idx + VL_W'(1);
      end
   end

   assign o_addr = r_addr;
   assign o_idx  = r_idx;
   assign o_last = (r_idx == (r_vl - VL_W'(1)));

endmodule

// File: rtl/vec_strided_lsu.sv
// Strided vector load/store initiator (vlse.v / vsse.v, SEW=32, LMUL=1).
// Accepts one command, then issues one word access per element on the
// valid/ready memory port, returning load data or pulling store data.
// Optional build macro VEC_LSU_PERF_EN adds saturating perf counters
// perf_accesses and perf_stall.
module vec_strided_lsu
   import vec_pkg::*;
#(
   parameter int VLMAX = 32,
   parameter int VL_W  = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_store,
   input  logic [31:0]     cmd_base,
   input  logic [31:0]     cmd_stride,
   input  logic [VL_W-1:0] cmd_vl,
   input  logic            st_valid,
   output logic            st_ready,
   input  logic [31:0]     st_data,
   output logic            ld_valid,
   output logic [VL_W-1:0] ld_idx,
   output logic [31:0]     ld_data,
   output logic            done,
   output logic            err,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [31:0]     mem_addr,
   output logic [31:0]     mem_wdata,
   output logic [3:0]      mem_wstrb,
   input  logic [31:0]     mem_rdata
`ifdef VEC_LSU_PERF_EN
   ,
   output logic [31:0]     perf_accesses,
   output logic [31:0]     perf_stall
`endif
);

   lsu_state_e      r_state;
   lsu_state_e      w_nextState;

   logic            r_store;
   logic            r_err;
   logic [31:0]     r_wdata;
   logic            r_ldValid;
   logic [VL_W-1:0] r_ldIdx;
   logic [31:0]     r_ldData;

   logic            w_accept;
   logic            w_misaligned;
   logic [VL_W-1:0] w_vlClamped;
   logic            w_handshake;
   logic            w_stTake;
   logic [31:0]     w_addr;
   logic [VL_W-1:0] w_idx;
   logic            w_last;

   assign w_accept     = (r_state == IDLE) && cmd_valid;
   assign w_misaligned = !isWordAligned(cmd_base[1:0]) || !isWordAligned(cmd_stride[1:0]);
   assign w_vlClamped  = (cmd_vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : cmd_vl;
   assign w_handshake  = (r_state == WAIT) && mem_ready;
   assign w_stTake     = (r_state == REQ) && r_store && st_valid;

   vec_lsu_addr_gen #(
      .VL_W     (VL_W)
   ) u_addrGen (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_accept),
      .i_base   (cmd_base),
      .i_stride (cmd_stride),
      .i_vl     (w_vlClamped),
      .i_step   (w_handshake),
      .o_addr   (w_addr),
      .o_idx    (w_idx),
      .o_last   (w_last)
   );

   // State register; reset always lands in IDLE with nothing in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake outputs; memory valid is only ever high in WAIT
   // so every element gets a bubble cycle after its handshake.
   always_comb begin
      w_nextState = r_state;
      cmd_ready   = 1'b0;
      st_ready    = 1'b0;
      mem_valid   = 1'b0;
      mem_wstrb   = WSTRB_NONE;
      done        = 1'b0;
      err         = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = !reset;
            if (cmd_valid) begin
               if (w_misaligned || (cmd_vl == '0)) begin
                  w_nextState = DONE;
               end else begin
                  w_nextState = REQ;
               end
            end
         end
         REQ: begin
            st_ready = r_store;
            if (!r_store || st_valid) begin
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            mem_valid = 1'b1;
            mem_wstrb = r_store ? WSTRB_WORD : WSTRB_NONE;
            if (mem_ready) begin
               w_nextState = w_last ? DONE : REQ;
            end
         end
         DONE: begin
            done        = 1'b1;
            err         = r_err;
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Command attributes kept for the whole operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_store <= 1'b0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_store <= cmd_store;
         r_err   <= w_misaligned;
      end
   end

   // Store data is captured once per element so it stays stable through WAIT.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wdata <= '0;
      end else if (w_stTake) begin
         r_wdata <= st_data;
      end
   end

   // Load return: one-cycle pulse after each load handshake with its index.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ldValid <= 1'b0;
         r_ldIdx   <= '0;
         r_ldData  <= '0;
      end else begin
         r_ldValid <= w_handshake && !r_store;
         if (w_handshake && !r_store) begin
            r_ldIdx  <= w_idx;
            r_ldData <= mem_rdata;
         end
      end
   end

   assign mem_addr  = w_addr;
   assign mem_wdata = r_wdata;
   assign ld_valid  = r_ldValid;
   assign ld_idx    = r_ldIdx;
   assign ld_data   = r_ldData;

`ifdef VEC_LSU_PERF_EN
   logic [31:0] r_perfAccesses;
   logic [31:0] r_perfStall;
   logic        w_stallCycle;

   assign w_stallCycle = ((r_state == WAIT) && !mem_ready) ||
                         ((r_state == REQ) && r_store && !st_valid);

   // Saturating counters for handshakes and for cycles spent waiting.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_perfAccesses <= '0;
         r_perfStall    <= '0;
      end else begin
         if (w_handshake && (r_perfAccesses != 32'hFFFF_FFFF)) begin
            r_perfAccesses <= r_perfAccesses + 32'd1;
         end
         if (w_stallCycle && (r_perfStall != 32'hFFFF_FFFF)) begin
            r_perfStall <= r_perfStall + 32'd1;
         end
      end
   end

   assign perf_accesses = r_perfAccesses;
   assign perf_stall    = r_perfStall;
`endif

endmodule

// File: tb/tb_vec_strided_lsu.sv
// Directed testbench for vec_strided_lsu: memory responder with adjustable
// latency, store-data feeder with an optional stall, and an access/load logger.
module tb_vec_strided_lsu;

   localparam int VLMAX = 32;
   localparam int VL_W  = 6;

   logic            clk = 1'b0;
   logic            reset;
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_store;
   logic [31:0]     cmd_base;
   logic [31:0]     cmd_stride;
   logic [VL_W-1:0] cmd_vl;
   logic            st_valid;
   logic            st_ready;
   logic [31:0]     st_data;
   logic            ld_valid;
   logic [VL_W-1:0] ld_idx;
   logic [31:0]     ld_data;
   logic            done;
   logic            err;
   logic            mem_valid;
   logic            mem_ready;
   logic [31:0]     mem_addr;
   logic [31:0]     mem_wdata;
   logic [3:0]      mem_wstrb;
   logic [31:0]     mem_rdata;
`ifdef VEC_LSU_PERF_EN
   logic [31:0]     perf_accesses;
   logic [31:0]     perf_stall;
`endif

   vec_strided_lsu #(
      .VLMAX (VLMAX),
      .VL_W  (VL_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_store  (cmd_store),
      .cmd_base   (cmd_base),
      .cmd_stride (cmd_stride),
      .cmd_vl     (cmd_vl),
      .st_valid   (st_valid),
      .st_ready   (st_ready),
      .st_data    (st_data),
      .ld_valid   (ld_valid),
      .ld_idx     (ld_idx),
      .ld_data    (ld_data),
      .done       (done),
      .err        (err),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_rdata  (mem_rdata)
`ifdef VEC_LSU_PERF_EN
      ,
      .perf_accesses (perf_accesses),
      .perf_stall    (perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mem [0:1023];
   logic [31:0] expLoad [0:7];

   int   respDelay    = 0;
   int   waitCnt      = 0;
   logic memHsPending = 1'b0;
   logic stHsPending  = 1'b0;

   logic [31:0] stVals [0:7];
   int   stCount     = 0;
   int   stIdx       = 0;
   int   stallIdx    = -1;
   int   stallCycles = 0;
   int   stallLeft   = 0;

   logic [31:0] accAddr  [0:63];
   logic [31:0] accWdata [0:63];
   logic [3:0]  accWstrb [0:63];
   logic [31:0] ldIdxLog [0:63];
   logic [31:0] ldDataLog[0:63];
   int   accCnt      = 0;
   int   ldCnt       = 0;
   int   ldWithDone  = 0;
   int   doneCnt     = 0;
   int   errCnt      = 0;
   int   validCycles = 0;
   int   unstable    = 0;
   int   cycleCnt    = 0;
   int   doneCyc     = 0;
   int   acceptCyc   = 0;
   logic        prevPending = 1'b0;
   logic [31:0] prevAddr    = '0;
   logic [31:0] prevWdata   = '0;
   logic [3:0]  prevWstrb   = '0;

   // Responder and store feeder react just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (memHsPending) begin
         mem_ready = 1'b0;
         waitCnt   = 0;
      end else if (mem_valid) begin
         if (!mem_ready) begin
            waitCnt++;
            if (waitCnt > respDelay) begin
               mem_ready = 1'b1;
               mem_rdata = mem[mem_addr[11:2]];
            end
         end
      end else begin
         mem_ready = 1'b0;
         waitCnt   = 0;
      end
      if (stHsPending) begin
         stIdx++;
         if (stIdx == stallIdx) stallLeft = stallCycles;
      end
      if (stallLeft > 0) begin
         st_valid = 1'b0;
         stallLeft--;
      end else if (stIdx < stCount) begin
         st_valid = 1'b1;
         st_data  = stVals[stIdx];
      end else begin
         st_valid = 1'b0;
      end
   end

   // Logger samples mid-cycle, after the falling edge.
   always @(negedge clk) begin
      #1;
      cycleCnt++;
      if (mem_valid) validCycles++;
      if (mem_valid && prevPending &&
          ((mem_addr !== prevAddr) || (mem_wdata !== prevWdata) || (mem_wstrb !== prevWstrb)))
         unstable++;
      prevPending  = mem_valid && !mem_ready;
      prevAddr     = mem_addr;
      prevWdata    = mem_wdata;
      prevWstrb    = mem_wstrb;
      memHsPending = mem_valid && mem_ready;
      stHsPending  = st_valid && st_ready;
      if (memHsPending) begin
         if (accCnt < 64) begin
            accAddr[accCnt]  = mem_addr;
            accWdata[accCnt] = mem_wdata;
            accWstrb[accCnt] = mem_wstrb;
         end
         accCnt++;
      end
      if (ld_valid) begin
         if (ldCnt < 64) begin
            ldIdxLog[ldCnt]  = 32'(ld_idx);
            ldDataLog[ldCnt] = ld_data;
         end
         ldCnt++;
         if (done) ldWithDone++;
      end
      if (done) begin
         doneCnt++;
         doneCyc = cycleCnt;
         if (err) errCnt++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic clearLog();
      accCnt = 0; ldCnt = 0; ldWithDone = 0; doneCnt = 0; errCnt = 0;
      validCycles = 0; unstable = 0; doneCyc = 0;
      stCount = 0; stIdx = 0; stallIdx = -1; stallCycles = 0; stallLeft = 0;
   endtask

   task automatic applyStimulus(input logic store, input logic [31:0] base,
                                input logic [31:0] stride, input logic [VL_W-1:0] vl);
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_store  = store;
      cmd_base   = base;
      cmd_stride = stride;
      cmd_vl     = vl;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      acceptCyc = cycleCnt;
   endtask

   task automatic waitDone(input int budget);
      int n = 0;
      while ((doneCnt == 0) && (n < budget)) begin
         @(negedge clk);
         #2;
         n++;
      end
      repeat (3) @(negedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      expLoad[0] = 32'h0000_0201; expLoad[1] = 32'h0000_0605;
      expLoad[2] = 32'h0000_0A09; expLoad[3] = 32'h0000_0E0D;
      expLoad[4] = 32'h1413_1211; expLoad[5] = 32'h1817_1615;
      expLoad[6] = 32'h1C1B_1A19; expLoad[7] = 32'h201F_1E1D;
      for (int i = 0; i < 8; i++) mem[100 + i] = expLoad[i];

      reset = 1'b1; cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = '0;
      cmd_stride = '0; cmd_vl = '0; st_valid = 1'b0; st_data = '0;
      mem_ready = 1'b0; mem_rdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      #2;
      checkOutput("rst_cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      #2;
      checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      checkOutput("rst_outputs", {24'd0, mem_valid, st_ready, ld_valid, done, err, mem_wstrb[2:0]}, 32'd0);
      checkOutput("rst_mem_addr", mem_addr, 32'd0);

      // Unit-word stride load of 8 elements
      clearLog(); respDelay = 0;
      applyStimulus(1'b0, 32'd400, 32'd4, 6'd8);
      waitDone(200);
      checkOutput("ld8_done", 32'(doneCnt), 32'd1);
      checkOutput("ld8_err", 32'(errCnt), 32'd0);
      checkOutput("ld8_acc", 32'(accCnt), 32'd8);
      checkOutput("ld8_ldcnt", 32'(ldCnt), 32'd8);
      checkOutput("ld8_last_with_done", 32'(ldWithDone), 32'd1);
      for (int i = 0; i < 8; i++) begin
         checkOutput($sformatf("ld8_addr%0d", i), accAddr[i], 32'd400 + 32'(4 * i));
         checkOutput($sformatf("ld8_wstrb%0d", i), 32'(accWstrb[i]), 32'd0);
         checkOutput($sformatf("ld8_idx%0d", i), ldIdxLog[i], 32'(i));
         checkOutput($sformatf("ld8_data%0d", i), ldDataLog[i], expLoad[i]);
      end

      // Store with a 3-cycle st_valid stall before element 2
      clearLog(); respDelay = 0;
      for (int i = 0; i < 4; i++) stVals[i] = 32'hA0 + 32'(i);
      stallIdx = 2; stallCycles = 3; stCount = 4;
      applyStimulus(1'b1, 32'd800, 32'd8, 6'd4);
      waitDone(200);
      checkOutput("st4_done", 32'(doneCnt), 32'd1);
      checkOutput("st4_acc", 32'(accCnt), 32'd4);
      checkOutput("st4_valid_cycles", 32'(validCycles), 32'd4);
      checkOutput("st4_ldcnt", 32'(ldCnt), 32'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("st4_addr%0d", i), accAddr[i], 32'd800 + 32'(8 * i));
         checkOutput($sformatf("st4_wdata%0d", i), accWdata[i], 32'hA0 + 32'(i));
         checkOutput($sformatf("st4_wstrb%0d", i), 32'(accWstrb[i]), 32'hF);
      end

      // Address wrap-around through zero
      clearLog(); respDelay = 0;
      applyStimulus(1'b0, 32'hFFFF_FFF8, 32'd4, 6'd4);
      waitDone(200);
      checkOutput("wrap_acc", 32'(accCnt), 32'd4);
      checkOutput("wrap_addr0", accAddr[0], 32'hFFFF_FFF8);
      checkOutput("wrap_addr1", accAddr[1], 32'hFFFF_FFFC);
      checkOutput("wrap_addr2", accAddr[2], 32'h0000_0000);
      checkOutput("wrap_addr3", accAddr[3], 32'h0000_0004);
      checkOutput("wrap_data0", ldDataLog[0], 32'hC0DE_03FE);
      checkOutput("wrap_data2", ldDataLog[2], 32'hC0DE_0000);

      // Negative stride
      clearLog(); respDelay = 0;
      applyStimulus(1'b0, 32'd412, 32'hFFFF_FFFC, 6'd3);
      waitDone(200);
      checkOutput("neg_acc", 32'(accCnt), 32'd3);
      checkOutput("neg_addr0", accAddr[0], 32'd412);
      checkOutput("neg_addr1", accAddr[1], 32'd408);
      checkOutput("neg_addr2", accAddr[2], 32'd404);
      checkOutput("neg_data0", ldDataLog[0], 32'h0000_0E0D);
      checkOutput("neg_data2", ldDataLog[2], 32'h0000_0605);

      // Misaligned base
      clearLog();
      applyStimulus(1'b0, 32'd402, 32'd4, 6'd4);
      waitDone(50);
      checkOutput("mis_base_done", 32'(doneCnt), 32'd1);
      checkOutput("mis_base_err", 32'(errCnt), 32'd1);
      checkOutput("mis_base_latency", 32'(doneCyc - acceptCyc), 32'd1);
      checkOutput("mis_base_valid_cycles", 32'(validCycles), 32'd0);

      // Misaligned stride
      clearLog();
      applyStimulus(1'b1, 32'd400, 32'd6, 6'd4);
      waitDone(50);
      checkOutput("mis_stride_err", 32'(errCnt), 32'd1);
      checkOutput("mis_stride_latency", 32'(doneCyc - acceptCyc), 32'd1);
      checkOutput("mis_stride_valid_cycles", 32'(validCycles), 32'd0);

      // Zero-length command
      clearLog();
      applyStimulus(1'b0, 32'd400, 32'd4, 6'd0);
      waitDone(50);
      checkOutput("vl0_done", 32'(doneCnt), 32'd1);
      checkOutput("vl0_err", 32'(errCnt), 32'd0);
      checkOutput("vl0_valid_cycles", 32'(validCycles), 32'd0);

      // Zero stride with vl above VLMAX clamps to 32 accesses at one address
      clearLog(); respDelay = 0;
      applyStimulus(1'b0, 32'd416, 32'd0, 6'd40);
      waitDone(400);
      checkOutput("clamp_acc", 32'(accCnt), 32'd32);
      checkOutput("clamp_addr31", accAddr[31], 32'd416);
      checkOutput("clamp_last_idx", ldIdxLog[31], 32'd31);
      checkOutput("clamp_data31", ldDataLog[31], 32'h1413_1211);

      // Slow responder: load then store, 5-cycle ready delay
      clearLog(); respDelay = 5;
      applyStimulus(1'b0, 32'd400, 32'd4, 6'd4);
      waitDone(300);
      checkOutput("slow_ld_acc", 32'(accCnt), 32'd4);
      checkOutput("slow_ld_ldcnt", 32'(ldCnt), 32'd4);
      checkOutput("slow_ld_valid_cycles", 32'(validCycles), 32'd24);
      checkOutput("slow_ld_unstable", 32'(unstable), 32'd0);
      checkOutput("slow_ld_data3", ldDataLog[3], 32'h0000_0E0D);
      clearLog(); respDelay = 5;
      stVals[0] = 32'hB0; stVals[1] = 32'hB1; stCount = 2;
      applyStimulus(1'b1, 32'd800, 32'd8, 6'd2);
      waitDone(300);
      checkOutput("slow_st_acc", 32'(accCnt), 32'd2);
      checkOutput("slow_st_unstable", 32'(unstable), 32'd0);
      checkOutput("slow_st_wdata1", accWdata[1], 32'hB1);
      checkOutput("slow_st_valid_cycles", 32'(validCycles), 32'd12);

      // Reset in WAIT on element 3 of 8
      clearLog(); respDelay = 30;
      applyStimulus(1'b0, 32'd400, 32'd4, 6'd8);
      for (int n = 0; n < 500; n++) begin
         if ((accCnt == 3) && mem_valid) break;
         @(negedge clk);
         #2;
      end
      checkOutput("rstmid_reached_wait", {31'd0, mem_valid}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rstmid_mem_valid", 32'(mem_valid), 32'd0);
      checkOutput("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
      repeat (40) @(negedge clk);
      #2;
      checkOutput("rstmid_no_done", 32'(doneCnt), 32'd0);
      checkOutput("rstmid_acc", 32'(accCnt), 32'd3);
      checkOutput("rstmid_ldcnt", 32'(ldCnt), 32'd3);
      clearLog(); respDelay = 0;
      applyStimulus(1'b0, 32'd400, 32'd4, 6'd2);
      waitDone(100);
      checkOutput("rstmid_new_done", 32'(doneCnt), 32'd1);
      checkOutput("rstmid_new_ldcnt", 32'(ldCnt), 32'd2);
      checkOutput("rstmid_new_data0", ldDataLog[0], 32'h0000_0201);
      checkOutput("rstmid_new_data1", ldDataLog[1], 32'h0000_0605);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
